mem_bus_master: RTL and testbench

Bus initiator for the main-memory slave port: accepts single-word or 16-byte line requests from a cache/fetch controller, sequences them into individual `cyc`/`we`/`strb`/`addr` word transfers, waits for `ack` on each beat, assembles read data into a 128-bit line and returns one response per request. It sits between the L1 cache controllers (or their arbiter) and the 32 kB main memory, and guards every beat with a watchdog so that a missing `ack` cannot hang the core.

---
 rtl/mem_bus_pkg.sv | 41 ++++
 rtl/bus_wdog.sv | 34 +++
 rtl/mem_bus_master.sv | 140 ++++++++++++++
 tb/tb_mem_bus_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the main-memory bus initiator and the cache controllers.
// Holds the bus widths, the FSM state type, the latched request payload and
// the address helpers.
package mem_bus_pkg;

  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STRB_W     = WORD_W / 8;
  localparam int unsigned BEAT_W     = 2;

  localparam logic [STRB_W-1:0] STRB_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_GAP,
    ST_RESP
  } state_t;

  // Request fields that must outlive the accept cycle
  typedef struct packed {
    logic              we;
    logic              line;
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] wdata;
  } req_t;

  // Line requests start on a 16-byte boundary, word requests on a 4-byte one
  function automatic logic [ADDR_W-1:0] align_base(input logic [ADDR_W-1:0] addr,
                                                   input logic              line);
    return line ? {addr[ADDR_W-1:4], 4'h0} : {addr[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] beat);
    return base + ADDR_W'({beat, 2'b00});
  endfunction

endpackage

// File: rtl/bus_wdog.sv
// Per-beat watchdog for the memory bus initiator.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : hold the count at zero (asserted whenever no beat is in flight)
//   en        : count one cycle of the current beat
//   expired   : high during the TIMEOUT_CYC-th cycle of a beat
module bus_wdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = 8;
  // expired is registered, so it is raised one cycle early
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] cnt;

  // Cycle counter; count k (0-based) is held during the (k+1)-th beat cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (en) begin
      cnt     <= cnt + CNT_W'(1);
      expired <= (cnt == LAST);
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator for the main-memory slave port. Turns single-word or 4-beat
// line requests into individual acknowledged word transfers, assembles read
// data into a 128-bit line and returns one response per request. A per-beat
// watchdog aborts a request whose beat is never acknowledged.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_*                    : request from cache/fetch controller (valid/ready)
//   resp_valid/err/rdata     : one-cycle completion pulse, abort flag, read line
//   m_cyc/we/strb/addr/data_o: registered word transfer to the slave
//   m_data_i, m_ack          : slave read data and acknowledge
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_line,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [STRB_W-1:0] req_strb,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              m_cyc,
  output logic              m_we,
  output logic [STRB_W-1:0] m_strb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_data_o,
  input  logic [WORD_W-1:0] m_data_i,
  input  logic              m_ack
);

  state_t            state;
  req_t              req_q;
  logic [BEAT_W-1:0] beat;
  logic              last_beat;
  logic              wdog_en;
  logic              wdog_clr;
  logic              wdog_expired;

  assign last_beat = req_q.line ? (beat == BEAT_W'(LINE_BEATS - 1)) : 1'b1;
  assign wdog_en   = (state == ST_BUS);
  assign wdog_clr  = ~wdog_en;

  bus_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // Request sequencer; all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      beat       <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      m_cyc      <= 1'b0;
      m_we       <= 1'b0;
      m_strb     <= '0;
      m_addr     <= '0;
      m_data_o   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_q.we    <= req_we;
            req_q.line  <= req_line;
            req_q.base  <= align_base(req_addr, req_line);
            req_q.wdata <= req_wdata;
            beat        <= '0;
            req_ready   <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            m_cyc       <= 1'b1;
            m_we        <= req_we;
            // only single-word writes honour the requester's byte enables
            m_strb      <= (req_we && !req_line) ? req_strb : STRB_ALL;
            m_addr      <= align_base(req_addr, req_line);
            m_data_o    <= req_wdata[WORD_W-1:0];
            state       <= ST_BUS;
          end
        end

        ST_BUS: begin
          // ack in the expiry cycle still completes the beat
          if (m_ack) begin
            if (!req_q.we) begin
              resp_rdata[int'(beat)*WORD_W +: WORD_W] <= m_data_i;
            end
            m_cyc <= 1'b0;
            if (last_beat) begin
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              beat  <= beat + BEAT_W'(1);
              state <= ST_GAP;
            end
          end else if (wdog_expired) begin
            m_cyc      <= 1'b0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end

        // one idle bus cycle lets the slave FSM return to idle between beats
        ST_GAP: begin
          m_cyc    <= 1'b1;
          m_addr   <= beat_addr(req_q.base, beat);
          m_data_o <= req_q.wdata[int'(beat)*WORD_W +: WORD_W];
          state    <= ST_BUS;
        end

        ST_RESP: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed vector table, reset
// corner cases and randomized requests against a request-level memory model.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int unsigned TO = 8;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic         req_line;
  logic [31:0]  req_addr;
  logic [3:0]   req_strb;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_err;
  logic [127:0] resp_rdata;
  logic         m_cyc;
  logic         m_we;
  logic [3:0]   m_strb;
  logic [31:0]  m_addr;
  logic [31:0]  m_data_o;
  logic [31:0]  m_data_i;
  logic         m_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_bus_master #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_line   (req_line),
    .req_addr   (req_addr),
    .req_strb   (req_strb),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .m_cyc      (m_cyc),
    .m_we       (m_we),
    .m_strb     (m_strb),
    .m_addr     (m_addr),
    .m_data_o   (m_data_o),
    .m_data_i   (m_data_i),
    .m_ack      (m_ack)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- slave model ----------------
  typedef struct packed {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [31:0] smem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  beat_t       log_q[$];
  int          s_lat  = 1;   // cycles of m_cyc per beat, ack in the last; 0 = never ack
  bit          s_spur = 1'b0; // drive ack while m_cyc is low
  int          s_run  = 0;
  int          gap_bad = 0;
  bit          s_prev = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    for (int b = 0; b < 4; b++) if (st[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  function automatic logic [31:0] rd_s(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_r(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    m_ack    = 1'b0;
    m_data_i = $urandom;
    if (rst) begin
      s_run  = 0;
      s_prev = 1'b0;
    end else if (m_cyc) begin
      if (s_prev) gap_bad++;
      s_prev = 1'b0;
      s_run++;
      if (s_lat != 0 && s_run == s_lat) begin
        m_ack  = 1'b1;
        s_prev = 1'b1;
        if (m_we) smem[m_addr] = merge(rd_s(m_addr), m_data_o, m_strb);
        else      m_data_i = rd_s(m_addr);
        log_q.push_back('{m_we, m_strb, m_addr, m_we ? m_data_o : 32'h0});
      end
    end else begin
      s_run  = 0;
      s_prev = 1'b0;
      m_ack  = s_spur;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic         we;
    logic         line;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] wdata;
    int           lat;
    logic         exp_err;
    int           exp_lat;   // cycles from accept to resp_valid, both inclusive
    logic         use_rd;
    logic [127:0] rd_exp;
  } vec_t;

  task automatic apply(input vec_t v, input string tag);
    beat_t        exp_q[$];
    logic [127:0] exp_rd;
    logic [127:0] mask;
    logic [31:0]  base;
    logic [31:0]  a;
    int           nb;
    int           cyc;
    nb     = v.line ? 4 : 1;
    base   = v.line ? (v.addr & ~32'hF) : (v.addr & ~32'h3);
    exp_rd = '0;
    mask   = '0;
    if (v.lat != 0) begin
      for (int n = 0; n < nb; n++) begin
        a = base + 32'(4 * n);
        if (v.we) begin
          exp_q.push_back('{1'b1, v.line ? 4'hF : v.strb, a, v.wdata[32*n +: 32]});
          ref_mem[a] = merge(rd_r(a), v.wdata[32*n +: 32], v.line ? 4'hF : v.strb);
        end else begin
          exp_q.push_back('{1'b0, 4'hF, a, 32'h0});
          exp_rd[32*n +: 32] = rd_r(a);
          mask[32*n +: 32]   = '1;
        end
      end
    end

    log_q.delete();
    gap_bad = 0;
    s_lat   = v.lat;
    cyc     = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".ready"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_we    = v.we;
    req_line  = v.line;
    req_addr  = v.addr;
    req_strb  = v.strb;
    req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_strb  = 4'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    cyc = 2;
    while (!resp_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"}, 128'(cyc), 128'(v.exp_lat));
    chk({tag, ".err"}, 128'(resp_err), 128'(v.exp_err));
    if (!v.we) chk({tag, ".rdata"}, resp_rdata & mask, exp_rd);
    if (v.use_rd) chk({tag, ".rdconst"}, resp_rdata & mask, v.rd_exp);
    chk({tag, ".nbeats"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s.beat%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
    chk({tag, ".gap"}, 128'(gap_bad), 128'(0));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 128'(resp_valid), 128'(0));
  endtask

  vec_t tab[10];

  initial begin
    vec_t v;
    int   cyc;
    bit   seen;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_line  = 1'b0;
    req_addr  = '0;
    req_strb  = '0;
    req_wdata = '0;

    smem[32'h1234]    = 32'hDEADBEEF;
    ref_mem[32'h1234] = 32'hDEADBEEF;
    smem[32'h2000]    = 32'hAABBCCDD;
    ref_mem[32'h2000] = 32'hAABBCCDD;

    // we line addr strb wdata lat err lat_exp use_rd rd_exp
    tab[0] = '{1'b0, 1'b0, 32'h1236, 4'h0, 128'h0, 2, 1'b0, 4, 1'b1, 128'hDEADBEEF};
    tab[1] = '{1'b1, 1'b1, 32'h0048, 4'h0, 128'h00000044_00000033_00000022_00000011,
               1, 1'b0, 9, 1'b0, 128'h0};
    tab[2] = '{1'b1, 1'b1, 32'h0100, 4'h0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000,
               3, 1'b0, 17, 1'b0, 128'h0};
    tab[3] = '{1'b0, 1'b1, 32'h010C, 4'h0, 128'h0, 3, 1'b0, 17, 1'b1,
               128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000};
    tab[4] = '{1'b1, 1'b0, 32'h2001, 4'b0110, 128'h11223344, 2, 1'b0, 4, 1'b0, 128'h0};
    tab[5] = '{1'b0, 1'b0, 32'h0300, 4'h0, 128'h0, 0, 1'b1, TO + 2, 1'b0, 128'h0};
    tab[6] = '{1'b0, 1'b0, 32'h1234, 4'h0, 128'h0, TO, 1'b0, TO + 2, 1'b1, 128'hDEADBEEF};
    tab[7] = '{1'b0, 1'b1, 32'h0040, 4'h0, 128'h0, 0, 1'b1, TO + 2, 1'b0, 128'h0};
    tab[8] = '{1'b1, 1'b0, 32'h2000, 4'h0, 128'hFFFFFFFF, 1, 1'b0, 3, 1'b0, 128'h0};
    tab[9] = '{1'b0, 1'b1, 32'h004F, 4'h0, 128'h0, 1, 1'b0, 9, 1'b1,
               128'h00000044_00000033_00000022_00000011};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 128'(req_ready), 128'(0));
    chk("rst.bus", 128'({m_cyc, m_we, m_strb, m_addr, m_data_o}), 128'(0));
    chk("rst.resp", 128'({resp_valid, resp_err}), 128'(0));
    chk("rst.rdata", resp_rdata, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.ready_after", 128'(req_ready), 128'(1));

    for (int i = 0; i < 10; i++) apply(tab[i], $sformatf("vec%0d", i));
    chk("mem.strb", 128'(rd_s(32'h2000)), 128'(32'hAA2233DD));

    // reset during beat 2 of a line read
    s_lat = 3;
    log_q.delete();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_line  = 1'b1;
    req_addr  = 32'h0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!(log_q.size() == 2 && m_cyc) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid.beat2_addr", 128'(m_addr), 128'(32'h88));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.cyc", 128'(m_cyc), 128'(0));
    chk("mid.resp", 128'(resp_valid), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid.ready", 128'(req_ready), 128'(1));
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("mid.noresp", 128'(seen), 128'(0));

    // randomized traffic against the request-level model
    for (int i = 0; i < 40; i++) begin
      v.we      = 1'($urandom);
      v.line    = 1'($urandom);
      v.addr    = $urandom_range(0, 255);
      v.strb    = 4'($urandom);
      v.wdata   = {$urandom, $urandom, $urandom, $urandom};
      v.lat     = $urandom_range(1, 4);
      v.exp_err = 1'b0;
      v.exp_lat = v.line ? 4 * v.lat + 5 : v.lat + 2;
      v.use_rd  = 1'b0;
      v.rd_exp  = '0;
      s_spur    = 1'($urandom);
      apply(v, $sformatf("rnd%0d", i));
    end
    s_spur = 1'b0;

    foreach (ref_mem[k]) chk($sformatf("mem[%h]", k), 128'(rd_s(k)), 128'(ref_mem[k]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
